adc_fetch_ctrl: RTL and testbench

FPGA-side initiator for the ADC capture/readout handshake. It issues the 16-bit command sequence (capture, read, read-over), pulls voltage then current samples word by word with the active-low read strobe, and forwards each word on a ready/valid stream toward the host link (UART/SPI framer). It sits between the capture buffer's command/strobe port and the outbound packetiser, on the buffer's read clock.

---
 rtl/adc_fetch_ctrl_if.sv | 24 ++
 rtl/adc_fetch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_adc_fetch_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fetch_ctrl_if.sv
// Buffer command/strobe port plus outbound word stream for adc_fetch_ctrl.
// master = fetch controller, slave = capture buffer and stream sink.
interface adc_fetch_ctrl_if;
  logic        save_over;
  logic [15:0] data_v;
  logic [15:0] data_i;
  logic [15:0] read_cmd;
  logic        r_en;
  logic [15:0] m_data;
  logic        m_chan;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport master (
    input  save_over, data_v, data_i, m_ready,
    output read_cmd, r_en, m_data, m_chan, m_last, m_valid
  );

  modport slave (
    output save_over, data_v, data_i, m_ready,
    input  read_cmd, r_en, m_data, m_chan, m_last, m_valid
  );
endinterface

// File: rtl/adc_fetch_ctrl.sv
// ADC capture/readout initiator: arm, wait for capture, strobe out V then I words onto a stream.
// Optional watchdog on WAIT_SAVE/PUSH is enabled by defining ADC_FETCH_TIMEOUT_EN.
module adc_fetch_ctrl #(
  parameter int N_WORDS  = 2048,
  parameter int CMD_HOLD = 220,
  parameter int LO_CYC   = 10,
  parameter int HI_CYC   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  adc_fetch_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int K_W      = $clog2(N_WORDS);
  localparam int HOLD_MAX = (CMD_HOLD > LO_CYC) ?
                            ((CMD_HOLD > HI_CYC) ? CMD_HOLD : HI_CYC) :
                            ((LO_CYC > HI_CYC) ? LO_CYC : HI_CYC);
  localparam int CNT_W    = $clog2(HOLD_MAX);

  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_HOLD - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LO_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(HI_CYC - 1);
  localparam logic [K_W-1:0]   K_FLUSH  = K_W'(N_WORDS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N_WORDS - 2);

  localparam logic [15:0] CMD_IDLE = 16'h0000;
  localparam logic [15:0] CMD_ARM  = 16'h00AA;
  localparam logic [15:0] CMD_READ = 16'h00CC;
  localparam logic [15:0] CMD_OVER = 16'h00DD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_SAVE,
    S_RD_CMD,
    S_STB_LO,
    S_PUSH,
    S_STB_HI,
    S_FIN
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [K_W-1:0]   k_reg;
  logic             chan_reg;
  logic [15:0]      read_cmd_reg;
  logic             r_en_reg;
  logic [15:0]      m_data_reg;
  logic             m_last_reg;
  logic             m_valid_reg;
  logic             busy_reg;
  logic             done_reg;

`ifdef ADC_FETCH_TIMEOUT_EN
  localparam logic [23:0] WDOG_LAST = 24'hFF_FFFE;
  logic [23:0] wdog_reg;
  logic        err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      k_reg        <= '0;
      chan_reg     <= 1'b0;
      read_cmd_reg <= CMD_IDLE;
      r_en_reg     <= 1'b1;
      m_data_reg   <= '0;
      m_last_reg   <= 1'b0;
      m_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef ADC_FETCH_TIMEOUT_EN
      wdog_reg     <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      cnt_reg  <= cnt_reg + 1'b1;
      case (state_reg)
        S_IDLE: begin
          cnt_reg <= '0;
          if (start) begin
            read_cmd_reg <= CMD_ARM;
            busy_reg     <= 1'b1;
            state_reg    <= S_ARM;
`ifdef ADC_FETCH_TIMEOUT_EN
            err_reg      <= 1'b0;
`endif
          end
        end
        S_ARM: begin
          if (cnt_reg == CMD_LAST) begin
            cnt_reg      <= '0;
            read_cmd_reg <= CMD_IDLE;
            state_reg    <= S_WAIT_SAVE;
          end
        end
        S_WAIT_SAVE: begin
          cnt_reg <= '0;
          if (bus.save_over) begin
            read_cmd_reg <= CMD_READ;
            state_reg    <= S_RD_CMD;
          end
        end
        S_RD_CMD: begin
          if (cnt_reg == CMD_LAST) begin
            cnt_reg   <= '0;
            chan_reg  <= 1'b0;
            k_reg     <= '0;
            r_en_reg  <= 1'b0;
            state_reg <= S_STB_LO;
          end
        end
        S_STB_LO: begin
          if (cnt_reg == LO_LAST) begin
            cnt_reg <= '0;
            // The last strobe of a channel only moves the responder past its end.
            if (k_reg != K_FLUSH) begin
              m_data_reg  <= chan_reg ? bus.data_i : bus.data_v;
              m_valid_reg <= 1'b1;
              m_last_reg  <= (k_reg == K_LAST);
              state_reg   <= S_PUSH;
            end else begin
              r_en_reg  <= 1'b1;
              state_reg <= S_STB_HI;
            end
          end
        end
        S_PUSH: begin
          cnt_reg <= '0;
          if (bus.m_ready) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            r_en_reg    <= 1'b1;
            state_reg   <= S_STB_HI;
          end
        end
        S_STB_HI: begin
          if (cnt_reg == HI_LAST) begin
            cnt_reg <= '0;
            k_reg   <= k_reg + 1'b1;
            if (k_reg == K_FLUSH) begin
              if (!chan_reg) begin
                chan_reg  <= 1'b1;
                k_reg     <= '0;
                r_en_reg  <= 1'b0;
                state_reg <= S_STB_LO;
              end else begin
                read_cmd_reg <= CMD_OVER;
                state_reg    <= S_FIN;
              end
            end else begin
              r_en_reg  <= 1'b0;
              state_reg <= S_STB_LO;
            end
          end
        end
        S_FIN: begin
          if (cnt_reg == CMD_LAST) begin
            cnt_reg      <= '0;
            read_cmd_reg <= CMD_IDLE;
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase

`ifdef ADC_FETCH_TIMEOUT_EN
      // Timeout overrides whatever the state decided this cycle and closes out via FIN.
      if (state_reg == S_WAIT_SAVE || state_reg == S_PUSH) begin
        wdog_reg <= wdog_reg + 1'b1;
        if (wdog_reg == WDOG_LAST) begin
          wdog_reg     <= '0;
          err_reg      <= 1'b1;
          cnt_reg      <= '0;
          read_cmd_reg <= CMD_OVER;
          r_en_reg     <= 1'b1;
          m_valid_reg  <= 1'b0;
          m_last_reg   <= 1'b0;
          state_reg    <= S_FIN;
        end
      end else begin
        wdog_reg <= '0;
      end
`endif
    end
  end

  assign bus.read_cmd = read_cmd_reg;
  assign bus.r_en     = r_en_reg;
  assign bus.m_data   = m_data_reg;
  assign bus.m_chan   = chan_reg;
  assign bus.m_last   = m_last_reg;
  assign bus.m_valid  = m_valid_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule

// File: tb/tb_adc_fetch_ctrl.sv
// Self-checking bench for adc_fetch_ctrl: table of full runs plus an async-reset sequence,
// against a strobe-counting buffer model and a word-list scoreboard.
module tb_adc_fetch_ctrl;

  localparam int N_WORDS  = 8;
  localparam int CMD_HOLD = 220;
  localparam int LO_CYC   = 10;
  localparam int HI_CYC   = 4;
  localparam int WPC      = N_WORDS - 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic err;

  adc_fetch_ctrl_if bus_if ();

  adc_fetch_ctrl #(
    .N_WORDS (N_WORDS),
    .CMD_HOLD(CMD_HOLD),
    .LO_CYC  (LO_CYC),
    .HI_CYC  (HI_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus_if),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        chan;
    logic        last;
  } word_t;

  typedef struct {
    logic [15:0] cmd;
    int          len;
  } seg_t;

  typedef struct {
    int ready_mode;   // 0 always ready, 1 ready one cycle in three, 2 random
    int save_mode;    // 0 save_over held high, 1 pulse during ARM then late assert
    bit poke_start;
    int exp_words;
    int exp_strobes;
    int exp_dones;
    int exp_busy;     // -1 when not checked
  } run_vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  word_t exp_q[$];
  seg_t  seg_q[$];

  bit          mon_en = 1'b0;
  int          ready_mode = 0;
  int          tick = 0;
  int          s_cnt = 0;
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  int          hs_count = 0;
  int          hi_len = 0;
  int          lo_len = 0;
  int          cur_len = 0;
  logic [15:0] cur_cmd = 16'h0000;
  logic        prev_ren = 1'b1;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [15:0] prev_data = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Buffer model, stream sink and scoreboard, all on the falling edge.
  always @(negedge clk) begin
    logic  hs;
    word_t w;
    tick++;
    if (!mon_en) begin
      prev_ren   = bus_if.r_en;
      cur_cmd    = bus_if.read_cmd;
      cur_len    = 0;
      hi_len     = 0;
      lo_len     = 0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      case (ready_mode)
        0:       bus_if.m_ready = 1'b1;
        1:       bus_if.m_ready = (tick % 3 == 0);
        default: bus_if.m_ready = 1'($urandom % 2);
      endcase

      if (bus_if.read_cmd === cur_cmd) begin
        cur_len++;
      end else begin
        seg_q.push_back('{cur_cmd, cur_len});
        if (bus_if.read_cmd === 16'h00CC) s_cnt = 0;
        cur_cmd = bus_if.read_cmd;
        cur_len = 1;
      end

      if (prev_ren && !bus_if.r_en) begin
        strobe_cnt++;
        if (s_cnt > 0) check("hi_phase_len", hi_len, HI_CYC);
        lo_len = 1;
      end else if (!prev_ren && !bus_if.r_en) begin
        lo_len++;
      end else if (!prev_ren && bus_if.r_en) begin
        s_cnt++;
        check("lo_phase_min", (lo_len >= LO_CYC), 1);
        hi_len = 1;
      end else begin
        hi_len++;
      end
      prev_ren = bus_if.r_en;
      bus_if.data_v = 16'(16'h0100 + s_cnt);
      bus_if.data_i = 16'(16'h0200 + s_cnt - N_WORDS);

      if (prev_valid && !prev_hs && bus_if.m_valid) check("m_data_stable", bus_if.m_data, prev_data);
      if (bus_if.m_valid) check("r_en_low_in_push", bus_if.r_en, 0);
      hs = bus_if.m_valid && bus_if.m_ready;
      if (hs) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("extra_word", bus_if.m_data, 16'hFFFF);
        end else begin
          w = exp_q.pop_front();
          check("word_data", bus_if.m_data, w.data);
          check("word_chan", bus_if.m_chan, w.chan);
          check("word_last", bus_if.m_last, w.last);
        end
      end
      prev_valid = bus_if.m_valid;
      prev_hs    = hs;
      prev_data  = bus_if.m_data;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic build_expected();
    exp_q.delete();
    for (int ch = 0; ch < 2; ch++) begin
      for (int a = 0; a < WPC; a++) begin
        exp_q.push_back('{16'((ch == 0 ? 16'h0100 : 16'h0200) + a), 1'(ch), (a == WPC - 1)});
      end
    end
  endtask

  task automatic run_seq(input run_vec_t v, input string tag);
    int guard;
    build_expected();
    seg_q.delete();
    strobe_cnt = 0;
    done_cnt   = 0;
    busy_cyc   = 0;
    hs_count   = 0;
    ready_mode = v.ready_mode;
    bus_if.save_over = (v.save_mode == 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_arm_next_edge"}, bus_if.read_cmd, 16'h00AA);
    check({tag, "_busy_set"}, busy, 1);
    if (v.save_mode == 1) begin
      repeat (100) @(negedge clk);
      bus_if.save_over = 1'b1;
      @(negedge clk);
      bus_if.save_over = 1'b0;
      repeat (300) @(negedge clk);
      bus_if.save_over = 1'b1;
    end
    if (v.poke_start) begin
      guard = 0;
      while (hs_count < 3 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 0, 1);
    repeat (30) @(negedge clk);
    bus_if.save_over = 1'b0;

    check({tag, "_done_count"}, done_cnt, v.exp_dones);
    check({tag, "_word_count"}, hs_count, v.exp_words);
    check({tag, "_strobe_count"}, strobe_cnt, v.exp_strobes);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_cmd_after"}, bus_if.read_cmd, 16'h0000);
    check({tag, "_err"}, err, 0);
    if (v.exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
    check({tag, "_cmd_segments"}, seg_q.size(), 5);
    if (seg_q.size() == 5) begin
      check({tag, "_seg_arm"}, seg_q[1].cmd, 16'h00AA);
      check({tag, "_seg_arm_len"}, seg_q[1].len, CMD_HOLD);
      check({tag, "_seg_wait"}, seg_q[2].cmd, 16'h0000);
      if (v.save_mode == 0) check({tag, "_seg_wait_len"}, seg_q[2].len, 1);
      else check({tag, "_seg_wait_long"}, (seg_q[2].len > 150), 1);
      check({tag, "_seg_read"}, seg_q[3].cmd, 16'h00CC);
      if (v.exp_busy >= 0)
        check({tag, "_seg_read_len"}, seg_q[3].len,
              CMD_HOLD + 2 * N_WORDS * (LO_CYC + HI_CYC) + 2 * WPC);
      check({tag, "_seg_over"}, seg_q[4].cmd, 16'h00DD);
      check({tag, "_seg_over_len"}, seg_q[4].len, CMD_HOLD);
    end
    $display("%s: words=%0d strobes=%0d dones=%0d busy_cycles=%0d", tag, hs_count, strobe_cnt,
             done_cnt, busy_cyc);
  endtask

  run_vec_t vecs[5];

  initial begin
    int guard;
    int min_busy;
    min_busy = 3 * CMD_HOLD + 1 + 2 * N_WORDS * (LO_CYC + HI_CYC) + 2 * WPC;
    vecs[0] = '{0, 0, 1'b0, 2 * WPC, 2 * N_WORDS, 1, min_busy};
    vecs[1] = '{1, 0, 1'b0, 2 * WPC, 2 * N_WORDS, 1, -1};
    vecs[2] = '{2, 1, 1'b1, 2 * WPC, 2 * N_WORDS, 1, -1};
    vecs[3] = '{2, 0, 1'b0, 2 * WPC, 2 * N_WORDS, 1, -1};
    vecs[4] = '{0, 1, 1'b1, 2 * WPC, 2 * N_WORDS, 1, -1};

    rst = 1'b0;
    start = 1'b0;
    bus_if.save_over = 1'b0;
    bus_if.data_v = 16'h0000;
    bus_if.data_i = 16'h0000;
    bus_if.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read_cmd", bus_if.read_cmd, 16'h0000);
    check("rst_r_en", bus_if.r_en, 1);
    check("rst_m_data", bus_if.m_data, 16'h0000);
    check("rst_m_chan", bus_if.m_chan, 0);
    check("rst_m_last", bus_if.m_last, 0);
    check("rst_m_valid", bus_if.m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start_busy", busy, 0);
    check("idle_no_start_cmd", bus_if.read_cmd, 16'h0000);
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_seq(vecs[i], $sformatf("run%0d", i));

    // Async reset while the current-channel word k=3 is being presented.
    build_expected();
    hs_count = 0;
    ready_mode = 0;
    bus_if.save_over = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (hs_count < WPC + 3 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    guard = 0;
    while (!bus_if.m_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reached_push", bus_if.m_valid, 1);
    check("midrst_word", bus_if.m_data, 16'h0203);
    check("midrst_chan", bus_if.m_chan, 1);
    check("midrst_r_en_low", bus_if.r_en, 0);
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("midrst_r_en", bus_if.r_en, 1);
    check("midrst_read_cmd", bus_if.read_cmd, 16'h0000);
    check("midrst_m_valid", bus_if.m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_chan_clr", bus_if.m_chan, 0);
    $display("midrst: reset applied after %0d words", hs_count);
    bus_if.save_over = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_stays_idle", busy, 0);
    mon_en = 1'b1;
    run_seq(vecs[0], "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
